// File: rtl/vector_div_seq_pkg.sv
// Shared types and default sizing for the sequential vector divider.
package vector_div_seq_pkg;

  localparam int unsigned DEF_N_BITS = 32;
  localparam int unsigned DEF_N_ELEM = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/divide_num.sv
// Combinational sign-magnitude divider; a zero divisor magnitude saturates the quotient magnitude.
module divide_num #(
  parameter int unsigned N_BITS_DIVISOR  = 32,
  parameter int unsigned N_BITS_DIVIDEND = 32,
  parameter int unsigned N_BITS_QUOTIENT = 32
) (
  input  logic [N_BITS_DIVIDEND-1:0] dividend,
  input  logic [N_BITS_DIVISOR-1:0]  divisor,
  output logic [N_BITS_QUOTIENT-1:0] quotient_c
);

  localparam int unsigned DM_W = N_BITS_DIVIDEND - 1;
  localparam int unsigned VM_W = N_BITS_DIVISOR - 1;
  localparam int unsigned QM_W = N_BITS_QUOTIENT - 1;
  localparam int unsigned CW   = (DM_W > VM_W) ? DM_W : VM_W;

  logic [CW-1:0]   a_mag;
  logic [CW-1:0]   b_mag;
  logic [CW-1:0]   q_full;
  logic [QM_W-1:0] q_mag;
  logic            q_sign;

  always_comb begin
    a_mag  = CW'(dividend[DM_W-1:0]);
    b_mag  = CW'(divisor[VM_W-1:0]);
    q_sign = dividend[N_BITS_DIVIDEND-1] ^ divisor[N_BITS_DIVISOR-1];
    q_full = '0;
    q_mag  = '1;
    if (b_mag != '0) begin
      q_full = a_mag / b_mag;
      q_mag  = QM_W'(q_full);
    end
    quotient_c = {q_sign, q_mag};
  end

endmodule

// File: rtl/vector_div_seq.sv
// Divides a stream of N_ELEM sign-magnitude dividends by one latched divisor,
// one element per LOAD/DIV/HOLD pass with valid/ready handshakes on both sides.
module vector_div_seq
  import vector_div_seq_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS,
  parameter int unsigned N_ELEM = DEF_N_ELEM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] divisor,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  cnt, cnt_n;
  logic [N_BITS-1:0] divisor_q;
  logic [N_BITS-1:0] dividend_q;
  logic [N_BITS-1:0] quotient_c;
  logic              latch_start;
  logic              load_en;
  logic              cap_en;

  divide_num #(
    .N_BITS_DIVISOR  (N_BITS),
    .N_BITS_DIVIDEND (N_BITS),
    .N_BITS_QUOTIENT (N_BITS)
  ) u_div (
    .dividend   (dividend_q),
    .divisor    (divisor_q),
    .quotient_c (quotient_c)
  );

  // Next-state, counter and register-enable decode
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    latch_start = 1'b0;
    load_en     = 1'b0;
    cap_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch_start = 1'b1;
          cnt_n       = '0;
          state_n     = LOAD;
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          load_en = 1'b1;
          state_n = DIV;
        end
      end
      DIV: begin
        cap_en  = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          if (cnt == LAST_IDX) begin
            state_n = DONE;
          end else begin
            cnt_n   = cnt + IDX_W'(1);
            state_n = LOAD;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      out_data   <= '0;
      div_zero   <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch_start) begin
        divisor_q <= divisor;
        div_zero  <= (divisor[N_BITS-2:0] == '0);
      end
      if (load_en) begin
        dividend_q <= in_data;
      end
      if (cap_en) begin
        out_data <= quotient_c;
      end
      in_ready  <= (state_n == LOAD);
      out_valid <= (state_n == HOLD);
      out_last  <= (state_n == HOLD) && (cnt_n == LAST_IDX);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: doc/vector_div_seq.md
VECTOR_DIV_SEQ -- requirements
Module: vector_div_seq

Interface
REQ-001 SHALL have parameter N_BITS, default 32, operand/quotient width in sign-magnitude form (MSB sign, N_BITS-1 magnitude bits).
REQ-002 SHALL have parameter N_ELEM, default 16, elements per vector; a local constant IDX_W = clog2(N_ELEM) sizes the element counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a vector; sampled only in IDLE.
REQ-006 SHALL have port divisor  input  N_BITS  common divisor, latched on an accepted start.
REQ-007 SHALL have port in_valid / in_ready / in_data  input / output / input  1 / 1 / N_BITS  dividend stream handshake.
REQ-008 SHALL have port out_valid / out_ready / out_data  output / input / output  1 / 1 / N_BITS  quotient stream handshake.
REQ-009 SHALL have port out_last  output  1  high with out_valid on element N_ELEM-1.
REQ-010 SHALL have ports busy, done, div_zero  output  1 each  block active; one-cycle completion pulse; sticky zero-divisor flag.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, DIV, HOLD, DONE.
REQ-012 IDLE: start=1 -> latch divisor, clear element counter and div_zero, go LOAD; busy high in all states except IDLE.
REQ-013 LOAD: in_ready=1; a transfer occurs when in_valid and in_ready are both high; in_data is registered into the dividend operand register; go DIV.
REQ-014 DIV: operand registers drive the combinational divider; its quotient is captured into out_data at the end of this cycle; go HOLD.
REQ-015 HOLD: out_valid=1 and out_data stable until out_ready=1; on handshake, if counter = N_ELEM-1 go DONE, else increment the counter and go LOAD.
REQ-016 DONE: done=1 for exactly one cycle; go IDLE.
REQ-017 Latency SHALL be an input handshake in cycle t -> out_valid first high in cycle t+2; throughput SHALL be one element per at most 3 cycles.
REQ-018 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside HOLD.
REQ-019 Quotient sign SHALL be the XOR of the operand sign bits; the magnitude SHALL be floor(|dividend| / |divisor|) over the N_BITS-1 magnitude bits.
REQ-020 Zero divisor magnitude SHALL set div_zero at the start latch, hold it until the next accepted start, and force each out_data to magnitude all ones, with the sign per REQ-019.
REQ-021 start while busy SHALL be ignored and SHALL NOT alter the latched divisor or the counter.
REQ-022 out_last SHALL equal (counter = N_ELEM-1) AND out_valid.
REQ-023 out_ready held low SHALL stall in HOLD indefinitely with no data loss; in_valid low SHALL stall in LOAD.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, with the counter, operand registers, out_data, div_zero, done, out_valid, in_ready and busy all 0.
REQ-025 Reset mid-vector SHALL abandon the vector; no done pulse; after release the block SHALL accept a fresh start normally.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and the default N_BITS/N_ELEM constants.
REQ-027 The division SHALL be one sub-module instance of divide_num, with N_BITS_DIVISOR, N_BITS_DIVIDEND and N_BITS_QUOTIENT all set to N_BITS; the FSM, counter and registers are in vector_div_seq.

Verification (N_BITS=32, N_ELEM=4)
REQ-028 Basic: divisor=10, dividends 100,55,9,0 with out_ready=1 -> out_data 10,5,0,0; out_last on the 4th; done one cycle after the 4th handshake.
REQ-029 Signs: divisor=0x8000000A (-10), dividends 0x80000064 (-100) and 100 -> 0x0000000A then 0x8000000A.
REQ-030 Backpressure: out_ready low for 5 cycles in HOLD -> out_data and out_valid held; in_ready stays 0; no element dropped or duplicated.
REQ-031 Zero divisor: divisor=0, dividend 7 -> div_zero=1 and out_data=0x7FFFFFFF; div_zero clears on the next start with divisor=3.
REQ-032 Reset/start abuse: rst_n pulsed low after element 2 -> all outputs 0 and no done; start pulsed mid-vector -> ignored, results unchanged.
